// File: rtl/pads_driver.sv
// Board-side 6502 pad driver: sequences n_RES, n_NMI, n_IRQ, RDY and SO from system requests.
// One CLK tick is one CPU bus cycle; every output comes straight from a flop.
//
// NMI FSM
//   state       | meaning
//   NMI_IDLE    | n_NMI high, waiting for a request edge
//   NMI_ASSERT  | n_NMI low for NMI_WIDTH cycles
//   NMI_RECOVER | n_NMI high for NMI_WIDTH cycles before another NMI may start
module pads_driver #(
   parameter int RES_CYCLES  = 8,
   parameter int NMI_WIDTH   = 2,
   parameter int WAIT_STATES = 1,
   parameter int IRQ_SRC     = 4
) (
   input  logic               CLK,
   input  logic               RES,
   input  logic               nmi_req,
   input  logic [IRQ_SRC-1:0] irq_src,
   input  logic [IRQ_SRC-1:0] irq_ack,
   input  logic               so_req,
   input  logic               slow_access,
   input  logic               RnW,
   input  logic               SYNC,
   output logic               n_RES,
   output logic               n_NMI,
   output logic               n_IRQ,
   output logic               RDY,
   output logic               SO,
   output logic [IRQ_SRC-1:0] irq_pending,
   output logic               in_reset
);

   typedef enum logic [1:0] {NMI_IDLE, NMI_ASSERT, NMI_RECOVER} nmi_state_t;

   nmi_state_t         nmi_state, nmi_state_d;
   logic [3:0]         nmi_cnt, nmi_cnt_d;
   logic               nmi_pend, nmi_pend_d;
   logic               n_nmi_d;
   logic               nmi_prev;
   logic [IRQ_SRC-1:0] irq_prev;
   logic [7:0]         res_cnt;
   logic [3:0]         rdy_cnt;
   logic               so_latch;
   logic               nmi_edge;
   logic [IRQ_SRC-1:0] irq_edge;
   logic               so_take;
   logic               unused_sync;

   // SYNC is watched but deliberately does not gate stretching
   assign unused_sync = SYNC;

   assign in_reset = ~n_RES;
   assign nmi_edge = nmi_req & ~nmi_prev & ~in_reset;
   assign irq_edge = irq_src & ~irq_prev & {IRQ_SRC{~in_reset}};
   assign so_take  = so_req & ~in_reset;

   always_comb begin
      nmi_state_d = nmi_state;
      nmi_cnt_d   = nmi_cnt;
      nmi_pend_d  = nmi_pend;
      case (nmi_state)
         NMI_IDLE: begin
            if (nmi_edge) begin
               nmi_state_d = NMI_ASSERT;
               nmi_cnt_d   = 4'(NMI_WIDTH - 1);
            end
         end
         NMI_ASSERT: begin
            if (nmi_edge) nmi_pend_d = 1'b1;
            if (nmi_cnt == 4'd0) begin
               nmi_state_d = NMI_RECOVER;
               nmi_cnt_d   = 4'(NMI_WIDTH - 1);
            end else begin
               nmi_cnt_d = nmi_cnt - 4'd1;
            end
         end
         NMI_RECOVER: begin
            if (nmi_cnt == 4'd0) begin
               // an edge on the last recovery cycle folds into the pending NMI
               if (nmi_pend || nmi_edge) begin
                  nmi_state_d = NMI_ASSERT;
                  nmi_cnt_d   = 4'(NMI_WIDTH - 1);
                  nmi_pend_d  = 1'b0;
               end else begin
                  nmi_state_d = NMI_IDLE;
               end
            end else begin
               nmi_cnt_d = nmi_cnt - 4'd1;
               if (nmi_edge) nmi_pend_d = 1'b1;
            end
         end
         default: nmi_state_d = NMI_IDLE;
      endcase
      n_nmi_d = (nmi_state_d != NMI_ASSERT);
   end

   always_ff @(posedge CLK) begin
      nmi_prev <= nmi_req;
      irq_prev <= irq_src;
      if (RES) begin
         n_RES       <= 1'b0;
         res_cnt     <= 8'(RES_CYCLES);
         nmi_state   <= NMI_IDLE;
         nmi_cnt     <= 4'd0;
         nmi_pend    <= 1'b0;
         n_NMI       <= 1'b1;
         irq_pending <= '0;
         n_IRQ       <= 1'b1;
         RDY         <= 1'b1;
         rdy_cnt     <= 4'd0;
         SO          <= 1'b1;
         so_latch    <= 1'b0;
      end else begin
         if (res_cnt != 8'd0) res_cnt <= res_cnt - 8'd1;
         else                 n_RES   <= 1'b1;

         nmi_state <= nmi_state_d;
         nmi_cnt   <= nmi_cnt_d;
         nmi_pend  <= nmi_pend_d;
         n_NMI     <= n_nmi_d;

         irq_pending <= (irq_pending & ~irq_ack) | irq_edge;
         n_IRQ       <= ~|irq_pending;

         // the cycle RDY returns high completes the access; a new slow read may start from it
         if (!RDY) begin
            if (rdy_cnt == 4'd0) RDY     <= 1'b1;
            else                 rdy_cnt <= rdy_cnt - 4'd1;
         end else if ((WAIT_STATES != 0) && slow_access && RnW && !in_reset) begin
            RDY     <= 1'b0;
            rdy_cnt <= 4'(WAIT_STATES - 1);
         end

         if (!SO) begin
            SO       <= 1'b1;
            so_latch <= so_take;
         end else if (so_latch || so_take) begin
            SO       <= 1'b0;
            so_latch <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pads_driver.sv
// Scoreboard bench for pads_driver: a time-window reference model queues expected pad levels per
// cycle; an independent monitor pops and compares after every rising clock edge.
module tb_pads_driver;

   localparam int RES_CYCLES  = 8;
   localparam int NMI_WIDTH   = 2;
   localparam int WAIT_STATES = 2;
   localparam int IRQ_SRC     = 4;

   logic               CLK = 1'b0;
   logic               RES, nmi_req, so_req, slow_access, RnW, SYNC;
   logic [IRQ_SRC-1:0] irq_src, irq_ack;
   logic               n_RES, n_NMI, n_IRQ, RDY, SO, in_reset;
   logic [IRQ_SRC-1:0] irq_pending;

   pads_driver #(.RES_CYCLES(RES_CYCLES), .NMI_WIDTH(NMI_WIDTH),
                 .WAIT_STATES(WAIT_STATES), .IRQ_SRC(IRQ_SRC)) dut (
      .CLK(CLK), .RES(RES), .nmi_req(nmi_req), .irq_src(irq_src), .irq_ack(irq_ack),
      .so_req(so_req), .slow_access(slow_access), .RnW(RnW), .SYNC(SYNC),
      .n_RES(n_RES), .n_NMI(n_NMI), .n_IRQ(n_IRQ), .RDY(RDY), .SO(SO),
      .irq_pending(irq_pending), .in_reset(in_reset));

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic               n_res, in_rst, n_nmi, n_irq, rdy, so;
      logic [IRQ_SRC-1:0] pend;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   pushed = 0;
   int   popped = 0;

   // reference model: events are remembered as edge indices, outputs derived from time windows
   int                 kk = 0;
   int                 rel = 0;
   int                 nmi_start = -1000;
   bit                 nmi_pend_m = 0;
   int                 rdy_start = -1000;
   int                 so_last = -1000;
   bit                 so_latch_m = 0;
   bit                 n_irq_m = 1;
   logic [IRQ_SRC-1:0] irq_m = '0;
   logic [IRQ_SRC-1:0] src_prev_m = '0;
   bit                 nmi_prev_m = 0;

   task automatic step(input bit res, input bit nmi, input logic [IRQ_SRC-1:0] src,
                       input logic [IRQ_SRC-1:0] ack, input bit so, input bit slow,
                       input bit rnw, input bit sync);
      bit   in_rst, nedge, rdy_before, req;
      exp_t e;
      RES = res; nmi_req = nmi; irq_src = src; irq_ack = ack;
      so_req = so; slow_access = slow; RnW = rnw; SYNC = sync;
      kk++;
      in_rst = !(rel > RES_CYCLES);
      if (res) begin
         rel = 0; nmi_start = -1000; nmi_pend_m = 0; irq_m = '0; n_irq_m = 1;
         rdy_start = -1000; so_last = -1000; so_latch_m = 0;
      end else begin
         if (rel < 1000) rel++;
         nedge = nmi && !nmi_prev_m && !in_rst;
         if (kk >= nmi_start + 2*NMI_WIDTH && (nedge || (nmi_pend_m && kk == nmi_start + 2*NMI_WIDTH))) begin
            nmi_start = kk; nmi_pend_m = 0;
         end else if (nedge) nmi_pend_m = 1;
         n_irq_m = (irq_m == '0);
         irq_m = (irq_m & ~ack) | (in_rst ? '0 : (src & ~src_prev_m));
         rdy_before = !((kk-1) >= rdy_start && (kk-1) < rdy_start + WAIT_STATES);
         if (rdy_before && slow && rnw && !in_rst && WAIT_STATES > 0) rdy_start = kk;
         req = so && !in_rst;
         if (kk-1 == so_last) so_latch_m = req;
         else if (so_latch_m || req) begin so_last = kk; so_latch_m = 0; end
      end
      nmi_prev_m = nmi; src_prev_m = src;
      e.n_res  = (rel > RES_CYCLES);
      e.in_rst = !(rel > RES_CYCLES);
      e.n_nmi  = !(kk >= nmi_start && kk < nmi_start + NMI_WIDTH);
      e.n_irq  = n_irq_m;
      e.rdy    = !(kk >= rdy_start && kk < rdy_start + WAIT_STATES);
      e.so     = (kk != so_last);
      e.pend   = irq_m;
      exp_q.push_back(e);
      pushed++;
      @(negedge CLK);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, 1, 0);
   endtask

   task automatic chk(input string name, input logic [IRQ_SRC-1:0] got, input logic [IRQ_SRC-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s cycle %0d got %0h want %0h", name, popped, got, want);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            popped++;
            chk("n_RES", {3'b0, n_RES}, {3'b0, e.n_res});
            chk("in_reset", {3'b0, in_reset}, {3'b0, e.in_rst});
            chk("n_NMI", {3'b0, n_NMI}, {3'b0, e.n_nmi});
            chk("n_IRQ", {3'b0, n_IRQ}, {3'b0, e.n_irq});
            chk("RDY", {3'b0, RDY}, {3'b0, e.rdy});
            chk("SO", {3'b0, SO}, {3'b0, e.so});
            chk("irq_pending", irq_pending, e.pend);
         end
      end
   end

   initial begin
      // reset release
      for (int i = 0; i < 3; i++) step(1, 0, '0, '0, 0, 0, 1, 0);
      idle(12);
      // NMI coalescing: pulses at t0, t0+1, t0+3
      step(0, 1, '0, '0, 0, 0, 1, 0);
      step(0, 1, '0, '0, 0, 0, 1, 0);
      step(0, 0, '0, '0, 0, 0, 1, 0);
      step(0, 1, '0, '0, 0, 0, 1, 0);
      idle(10);
      // IRQ pending and ack, set wins over ack
      step(0, 0, 4'b0101, '0, 0, 0, 1, 0);
      step(0, 0, '0, '0, 0, 0, 1, 0);
      idle(2);
      step(0, 0, '0, 4'b0001, 0, 0, 1, 0);
      idle(2);
      step(0, 0, 4'b0100, 4'b0100, 0, 0, 1, 0);
      idle(2);
      step(0, 0, '0, 4'b0100, 0, 0, 1, 0);
      idle(3);
      // wait states: single slow read, back-to-back slow reads, slow writes, slow opcode fetch
      step(0, 0, '0, '0, 0, 1, 1, 0);
      idle(4);
      for (int i = 0; i < 6; i++) step(0, 0, '0, '0, 0, 1, 1, 0);
      idle(2);
      for (int i = 0; i < 4; i++) step(0, 0, '0, '0, 0, 1, 0, 0);
      step(0, 0, '0, '0, 0, 1, 1, 1);
      idle(4);
      // SO burst of three requests
      for (int i = 0; i < 3; i++) step(0, 0, '0, '0, 1, 0, 1, 0);
      idle(4);
      // reset during NMI assert and during an RDY stretch
      step(0, 1, 4'b0010, '0, 0, 0, 1, 0);
      step(1, 0, '0, '0, 0, 0, 1, 0);
      idle(12);
      step(0, 0, '0, '0, 1, 1, 1, 0);
      step(1, 0, '0, '0, 0, 1, 1, 0);
      idle(12);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [IRQ_SRC-1:0] src, ack;
         for (int b = 0; b < IRQ_SRC; b++) begin
            src[b] = ($urandom_range(0, 3) == 0);
            ack[b] = ($urandom_range(0, 5) == 0);
         end
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), src, ack,
              ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      idle(2);
      repeat (3) @(negedge CLK);
      checks++;
      if (exp_q.size() != 0 || popped != pushed) begin
         errors++;
         $display("FAIL drain popped %0d want %0d", popped, pushed);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
